// File: rtl/openmips_min_sopc_top_pkg.sv
// Shared definitions for the minimal OpenMIPS SoC: the instruction encoding,
// datapath widths, ALU operations and the write-back bundle that travels down
// the pipeline.
package openmips_min_sopc_top_pkg;

  localparam int DATA_W  = 32;
  localparam int INST_W  = 32;
  localparam int REG_AW  = 5;
  localparam int REG_NUM = 32;

  localparam logic [5:0]        ORI      = 6'b001101;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    ALU_NOP = 2'd0,
    ALU_OR  = 2'd1
  } aluop_e;

  // Register write request produced in EX and carried through MEM to WB.
  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_t;

  localparam wb_t WB_NOP = '{we: 1'b0, waddr: '0, wdata: '0};

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return {16'h0, v};
  endfunction

endpackage

// File: rtl/openmips_min_sopc_top_inst_rom.sv
// inst_rom: combinational instruction ROM, contents loaded from outside.
//   ce   : chip enable; output is 0 while low
//   addr : byte address (PC); word index is addr[ROM_AW+1:2]
//   inst : instruction word, 0 for indices at or beyond ROM_DEPTH
module inst_rom
  import openmips_min_sopc_top_pkg::*;
#(
  parameter int ROM_DEPTH = 128,
  parameter int ROM_AW    = 7
) (
  input  logic              ce,
  input  logic [DATA_W-1:0] addr,
  output logic [INST_W-1:0] inst
);

  logic [INST_W-1:0] inst_mem [0:ROM_DEPTH-1];
  logic [ROM_AW-1:0] idx;
  logic              in_range;
  logic              unused_addr_bits;

  assign idx              = addr[ROM_AW+1:2];
  assign unused_addr_bits = ^{addr[DATA_W-1:ROM_AW+2], addr[1:0]};

  // A power-of-two ROM covers every index; otherwise the top of the index
  // space reads as 0.
  if (ROM_DEPTH >= (1 << ROM_AW)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    localparam logic [ROM_AW:0] DEPTH_LIM = ROM_DEPTH[ROM_AW:0];
    assign in_range = ({1'b0, idx} < DEPTH_LIM);
  end

  always_comb begin
    inst = NOP_INST;
    if (ce && in_range) inst = inst_mem[idx];
  end

endmodule

// File: rtl/openmips_min_sopc_top_openmips.sv
// openmips: 5-stage (IF, ID, EX, MEM, WB) in-order core executing ORI only.
//   clk, rst : clock, synchronous active-high reset
//   inst     : instruction fetched from the ROM at pc
//   pc       : byte address of the fetch, +4 per cycle, no branches
//   ce       : ROM chip enable, a registered copy of ~rst
// EX and MEM results are forwarded into ID, so dependent instructions issue
// back to back without stalls.
module openmips
  import openmips_min_sopc_top_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst,
  output logic [DATA_W-1:0] pc,
  output logic              ce
);

  // IF
  logic [INST_W-1:0] if_id_inst;

  always_ff @(posedge clk) begin
    ce <= ~rst;
    if (rst || !ce) pc <= '0;
    else            pc <= pc + 32'd4;
    if_id_inst <= rst ? NOP_INST : inst;
  end

  // ID
  logic [REG_AW-1:0] rs, rt;
  logic [DATA_W-1:0] imm_ext, rdata1, rdata2, op1, op2;
  logic              re1, re2, id_we;
  logic [REG_AW-1:0] id_waddr;
  aluop_e            id_aluop;
  wb_t               ex_out, ex_mem, mem_out, mem_wb;

  assign rs = if_id_inst[25:21];
  assign rt = if_id_inst[20:16];

  always_comb begin
    id_aluop = ALU_NOP;
    id_we    = 1'b0;
    id_waddr = '0;
    re1      = 1'b0;
    re2      = 1'b0;
    imm_ext  = '0;
    if (if_id_inst[31:26] == ORI) begin
      id_aluop = ALU_OR;
      id_we    = 1'b1;
      id_waddr = rt;
      re1      = 1'b1;
      imm_ext  = zext16(if_id_inst[15:0]);
    end
  end

  // Operand not read from a register takes the immediate. Register 0 is
  // never forwarded so it keeps reading 0 even right after an ORI to $0.
  function automatic logic [DATA_W-1:0] operand(
    input logic re, input logic [REG_AW-1:0] ra, input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] rf, input wb_t ex, input wb_t mem);
    if (!re) return imm;
    if ((ra != '0) && ex.we && (ex.waddr == ra))   return ex.wdata;
    if ((ra != '0) && mem.we && (mem.waddr == ra)) return mem.wdata;
    return rf;
  endfunction

  assign op1 = operand(re1, rs, imm_ext, rdata1, ex_out, mem_out);
  assign op2 = operand(re2, rt, imm_ext, rdata2, ex_out, mem_out);

  regfile regfile1 (
    .clk    (clk),
    .rst    (rst),
    .we     (mem_wb.we),
    .waddr  (mem_wb.waddr),
    .wdata  (mem_wb.wdata),
    .re1    (re1),
    .raddr1 (rs),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (rt),
    .rdata2 (rdata2)
  );

  // ID/EX
  aluop_e            id_ex_aluop;
  logic [DATA_W-1:0] id_ex_op1, id_ex_op2;
  logic              id_ex_we;
  logic [REG_AW-1:0] id_ex_waddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_aluop <= ALU_NOP;
      id_ex_op1   <= '0;
      id_ex_op2   <= '0;
      id_ex_we    <= 1'b0;
      id_ex_waddr <= '0;
    end else begin
      id_ex_aluop <= id_aluop;
      id_ex_op1   <= op1;
      id_ex_op2   <= op2;
      id_ex_we    <= id_we;
      id_ex_waddr <= id_waddr;
    end
  end

  // EX
  always_comb begin
    ex_out.we    = id_ex_we;
    ex_out.waddr = id_ex_waddr;
    ex_out.wdata = (id_ex_aluop == ALU_OR) ? (id_ex_op1 | id_ex_op2) : '0;
  end

  // EX/MEM, MEM (no data memory: pass-through), MEM/WB
  assign mem_out = ex_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem <= WB_NOP;
      mem_wb <= WB_NOP;
    end else begin
      ex_mem <= ex_out;
      mem_wb <= mem_out;
    end
  end

endmodule

// File: rtl/openmips_min_sopc_top_regfile.sv
// regfile: 32 x 32-bit general-purpose registers, two read ports, one write
// port.
//   clk, rst            : clock, synchronous active-high clear of all registers
//   we, waddr, wdata    : write port (writes to register 0 are dropped)
//   re1/raddr1 -> rdata1: read port 1
//   re2/raddr2 -> rdata2: read port 2
// Reads bypass the write port, so an instruction in ID sees a value being
// written back in the same cycle.
module regfile
  import openmips_min_sopc_top_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [0:REG_NUM-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (re1 && (raddr1 != '0))
      rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (re2 && (raddr2 != '0))
      rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/openmips_min_sopc_top.sv
// openmips_min_sopc_top: minimal SoC = openmips core + instruction ROM.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
// The ROM image is loaded and the register file observed through hierarchy.
module openmips_min_sopc_top
  import openmips_min_sopc_top_pkg::*;
#(
  parameter int ROM_DEPTH = 128,
  parameter int ROM_AW    = 7
) (
  input logic clk,
  input logic rst
);

  logic [DATA_W-1:0] pc;
  logic [INST_W-1:0] inst;
  logic              ce;

  openmips openmips0 (
    .clk  (clk),
    .rst  (rst),
    .inst (inst),
    .pc   (pc),
    .ce   (ce)
  );

  inst_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .ROM_AW    (ROM_AW)
  ) inst_rom0 (
    .ce   (ce),
    .addr (pc),
    .inst (inst)
  );

endmodule

// File: tb/tb_openmips_min_sopc_top.sv
module tb_openmips_min_sopc_top;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [31:0] prog  [0:127];
  logic [31:0] mregs [0:31];

  openmips_min_sopc_top dut (.clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rom();
    for (int i = 0; i < 128; i++) dut.inst_rom0.inst_mem[i] = prog[i];
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) prog[i] = 32'h0;
  endtask

  // Architectural model: each instruction applied in program order.
  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
  endtask

  task automatic model_exec(input logic [31:0] w);
    logic [4:0] s, t;
    s = w[25:21];
    t = w[20:16];
    if (w[31:26] == 6'b001101 && t != 5'd0)
      mregs[t] = mregs[s] | {16'h0, w[15:0]};
  endtask

  function automatic logic [31:0] rand_ori(input int maxr);
    logic [4:0] s, t;
    s = 5'($urandom_range(0, maxr));
    t = 5'($urandom_range(0, maxr));
    return {6'b001101, s, t, 16'($urandom)};
  endfunction

  function automatic logic [31:0] rand_other();
    logic [5:0] op;
    op = 6'($urandom_range(0, 62));
    if (op >= 6'd13) op = op + 6'd1;
    return {op, 26'($urandom)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clear_prog();
    prog[0] = 32'h34010011;
    load_rom();
    repeat (10) tick();
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (dut.openmips0.regfile1.regs[i] !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_regs r%0d: got %h want 00000000", i, dut.openmips0.regfile1.regs[i]);
      end
    end
    n_cmp++;
    if (dut.openmips0.pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_pc: got %h want 00000000", dut.openmips0.pc);
    end
    n_cmp++;
    if (dut.openmips0.ce !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ce: got %b want 0", dut.openmips0.ce);
    end
    n_cmp++;
    if (dut.inst !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_inst: got %h want 00000000", dut.inst);
    end
  endtask

  task automatic test_directed();
    logic [31:0] r;
    clear_prog();
    prog[0] = 32'h34010011;  // ori $1,$0,0x0011
    prog[1] = 32'h34220100;  // ori $2,$1,0x0100
    prog[2] = 32'h3403FFFF;  // ori $3,$0,0xFFFF
    prog[3] = 32'h34051100;  // ori $5,$0,0x1100
    prog[4] = 32'h34A50020;  // ori $5,$5,0x0020
    prog[5] = 32'h34A54400;  // ori $5,$5,0x4400
    prog[6] = 32'h34A50044;  // ori $5,$5,0x0044
    prog[7] = 32'h34A01234;  // ori $0,$5,0x1234
    prog[8] = 32'h34060001;  // ori $6,$0,0x0001
    load_rom();
    model_reset();
    rst = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (e >= 5) model_exec(prog[e-5]);
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (dut.openmips0.regfile1.regs[i] !== mregs[i]) begin
          n_bad++;
          $display("FAIL directed_model edge E0+%0d r%0d: got %h want %h",
                   e, i, dut.openmips0.regfile1.regs[i], mregs[i]);
        end
      end
      r = 32'h0;
      case (e)
        5:  r = 32'h00000011;
        6:  r = 32'h00000111;
        7:  r = 32'h0000FFFF;
        8:  r = 32'h00001100;
        9:  r = 32'h00001120;
        10: r = 32'h00005520;
        11: r = 32'h00005564;
        12: r = 32'h00000000;
        13: r = 32'h00000001;
        default: r = 32'h0;
      endcase
      if (e >= 5 && e <= 13) begin
        logic [31:0] got;
        int          reg_no;
        reg_no = (e == 5) ? 1 : (e == 6) ? 2 : (e == 7) ? 3 : (e == 12) ? 0 : (e == 13) ? 6 : 5;
        got = dut.openmips0.regfile1.regs[reg_no];
        n_cmp++;
        if (got !== r) begin
          n_bad++;
          $display("FAIL directed_const edge E0+%0d r%0d: got %h want %h", e, reg_no, got, r);
        end
      end
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    clear_prog();
    for (int k = 0; k < 40; k++) begin
      logic [4:0] t;
      t = 5'($urandom_range(1, 3));
      prog[k] = {6'b001101, t, t, 16'($urandom)};
    end
    load_rom();
    model_reset();
    rst = 1'b0;
    for (int e = 0; e < 48; e++) begin
      tick();
      if (e >= 5) model_exec(prog[e-5]);
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (dut.openmips0.regfile1.regs[i] !== mregs[i]) begin
          n_bad++;
          $display("FAIL back_to_back edge E0+%0d r%0d: got %h want %h",
                   e, i, dut.openmips0.regfile1.regs[i], mregs[i]);
        end
      end
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_random();
    clear_prog();
    for (int k = 0; k < 100; k++)
      prog[k] = ($urandom_range(0, 4) == 0) ? rand_other() : rand_ori(7);
    load_rom();
    model_reset();
    rst = 1'b0;
    for (int e = 0; e < 110; e++) begin
      tick();
      if (e >= 5) model_exec(prog[e-5]);
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (dut.openmips0.regfile1.regs[i] !== mregs[i]) begin
          n_bad++;
          $display("FAIL random edge E0+%0d r%0d: got %h want %h",
                   e, i, dut.openmips0.regfile1.regs[i], mregs[i]);
        end
      end
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_midrun_reset();
    clear_prog();
    for (int k = 0; k < 40; k++) prog[k] = rand_ori(6);
    load_rom();
    for (int pass = 0; pass < 2; pass++) begin
      model_reset();
      rst = 1'b0;
      for (int e = 0; e < ((pass == 0) ? 20 : 50); e++) begin
        tick();
        if (e >= 5) model_exec(prog[e-5]);
        for (int i = 0; i < 32; i++) begin
          n_cmp++;
          if (dut.openmips0.regfile1.regs[i] !== mregs[i]) begin
            n_bad++;
            $display("FAIL midrun pass%0d edge E0+%0d r%0d: got %h want %h",
                     pass, e, i, dut.openmips0.regfile1.regs[i], mregs[i]);
          end
        end
      end
      rst = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (dut.openmips0.regfile1.regs[i] !== 32'h0) begin
          n_bad++;
          $display("FAIL midrun_clear pass%0d r%0d: got %h want 00000000",
                   pass, i, dut.openmips0.regfile1.regs[i]);
        end
      end
      n_cmp++;
      if (dut.openmips0.pc !== 32'h0 || dut.openmips0.ce !== 1'b0) begin
        n_bad++;
        $display("FAIL midrun_pc_ce pass%0d: got pc=%h ce=%b want pc=00000000 ce=0",
                 pass, dut.openmips0.pc, dut.openmips0.ce);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
